// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshake and a one-bit-per-cycle serial shifter.
// Define ALU_BARREL_SHIFT_EN to compute shifts combinationally at accept, which makes every op single-cycle.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  accept;
  logic [SHAMT_W-1:0]    shamt;

  function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [3:0] op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [SHAMT_W-1:0]           sh;
    logic [DATA_WIDTH-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHAMT_W-1:0];
    r  = '0;
    case (op)
      4'b0000:         r = a & b;
      4'b0001:         r = a ^ b;
      4'b0010:         r = a | b;
      4'b0011:         r = a + b;
      4'b0100:         r = a - b;
      4'b0101:         r = {{(DATA_WIDTH-1){1'b0}}, a == b};
      4'b0110, 4'b0111: r = {{(DATA_WIDTH-1){1'b0}}, sa < sb};
      4'b1000:         r = {{(DATA_WIDTH-1){1'b0}}, sa >= sb};
      OP_SRL:          r = a >> sh;
      OP_SLL:          r = a << sh;
      OP_SRA:          r = sa >>> sh;
      4'b1100:         r = b;
      default:         r = '0;
    endcase
    return r;
  endfunction

  assign shamt     = SrcB[SHAMT_W-1:0];
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign ALUResult = res_q;

`ifdef ALU_BARREL_SHIFT_EN

  assign Busy = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else if (accept) begin
      state_q <= DONE;
      res_q   <= alu_op(Operation, SrcA, SrcB);
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end

`else

  logic [SHAMT_W-1:0] cnt_q;
  logic [3:0]         op_q;
  logic               is_shift;

  // One-bit step of the serial shifter; SRA replicates the sign bit.
  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: r = {1'b0, v[DATA_WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign is_shift = (Operation == OP_SRL) || (Operation == OP_SLL) || (Operation == OP_SRA);
  assign Busy     = (state_q == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        SHIFT: begin
          res_q <= shift_step(op_q, res_q);
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) state_q <= DONE;
        end
        default: begin
          if (accept) begin
            if (is_shift && shamt != '0) begin
              state_q <= SHIFT;
              res_q   <= SrcA;
              cnt_q   <= shamt;
              op_q    <= Operation;
            end else begin
              state_q <= DONE;
              res_q   <= alu_op(Operation, SrcA, SrcB);
            end
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake corner sequences and randomized ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result: shifts are done as multiplication/floor division by powers of two.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint p, ua, sa, two;
    int s;
    s   = int'(b % 32);
    two = 2;
    p   = two ** s;
    ua  = longint'({32'b0, a});
    sa  = longint'($signed(a));
    case (op)
      4'd0:       return a & b;
      4'd1:       return a ^ b;
      4'd2:       return a | b;
      4'd3:       return 32'(ua + longint'({32'b0, b}));
      4'd4:       return 32'(ua - longint'({32'b0, b}));
      4'd5:       return (a == b) ? 32'd1 : 32'd0;
      4'd6, 4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:       return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd9:       return 32'(ua / p);
      4'd10:      return 32'(ua * p);
      4'd11:      return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      4'd12:      return b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'd9 || op == 4'd10 || op == 4'd11) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Issue one op with out_ready high; measure latency and Busy cycles, then check.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int lat, busy, guard, el;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (Busy) busy++;
    end while (!out_valid && lat < 40);
    el = exp_lat(op, b);
    chk({name, "_result"}, ALUResult, exp);
    chk({name, "_latency"}, 32'(lat), 32'(el));
    chk({name, "_busy"}, 32'(busy), 32'(el - 1));
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{4'd4,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[2]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[3]  = '{4'd7,  32'h00000005, 32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[5]  = '{4'd8,  32'h00000007, 32'h00000007, 32'h00000001};
    vecs[6]  = '{4'd5,  32'h00001234, 32'h00001234, 32'h00000001};
    vecs[7]  = '{4'd5,  32'h00001234, 32'h00001235, 32'h00000000};
    vecs[8]  = '{4'd12, 32'h00000000, 32'hABCDE000, 32'hABCDE000};
    vecs[9]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[10] = '{4'd2,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vecs[11] = '{4'd1,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F};
    vecs[12] = '{4'd11, 32'hF0000000, 32'h00000004, 32'hFF000000};
    vecs[13] = '{4'd10, 32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[14] = '{4'd9,  32'h00001234, 32'h00000000, 32'h00001234};
    vecs[15] = '{4'd9,  32'h80000000, 32'h00000014, 32'h00000800};
    vecs[16] = '{4'd11, 32'h40000000, 32'h00000021, 32'h20000000};
    vecs[17] = '{4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
    vecs[18] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 19; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back ADD then SUB with out_ready high.
    @(negedge clk);
    Operation = 4'd3; SrcA = 32'hFFFFFFFF; SrcB = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1 Operation = 4'd4; SrcA = 32'h5; SrcB = 32'h7;
    @(negedge clk);
    chk("b2b_add_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_add_result", ALUResult, 32'h00000000);
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_sub_result", ALUResult, 32'hFFFFFFFE);
    @(negedge clk);
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: result held, offered op not accepted.
    out_ready = 1'b0;
    Operation = 4'd1; SrcA = 32'hFF00FF00; SrcB = 32'h0F0F0F0F; in_valid = 1'b1;
    @(posedge clk);
    #1 Operation = 4'd3; SrcA = 32'h1; SrcB = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", ALUResult, 32'hF00FF00F);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'b0, out_valid}, 32'd0);
    chk("bp_result_kept", ALUResult, 32'hF00FF00F);

`ifndef ALU_BARREL_SHIFT_EN
    // Reset in the middle of a long serial shift.
    Operation = 4'd9; SrcA = 32'h80000000; SrcB = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 chk("mid_busy", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_result", ALUResult, 32'd0);
    chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_no_result", {31'b0, out_valid}, 32'd0);
`endif

    // Randomized ops against the reference model.
    for (int i = 0; i < 250; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) b = b & 32'h1F;
      do_op(op, a, b, ref_alu(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d compares done", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage ALU sitting directly downstream of the ALU controller: consumes the controller's 4-bit `Operation` code plus two operands and returns a registered result over a valid/ready handshake. Logic/arithmetic/compare ops complete in one cycle. Shifts run on an area-saving serial shifter, one bit per cycle, unless the barrel-shifter option is compiled in. The pipeline control stalls issue on `in_ready`.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be a power of two ≥ 8.
- `SHAMT_W`, $clog2(DATA_WIDTH), shift-amount width taken from `SrcB[SHAMT_W-1:0]`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and `Operation` valid.
- `in_ready`  out  1  unit can accept this cycle.
- `Operation`  in  4  op code from ALU controller.
- `SrcA`  in  DATA_WIDTH  operand A (rs1 / PC).
- `SrcB`  in  DATA_WIDTH  operand B (rs2 / immediate).
- `out_valid`  out  1  `ALUResult` valid.
- `out_ready`  in  1  consumer takes result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Busy`  out  1  high in SHIFT state.

## Operation
- Op map: 0000 AND, 0001 XOR, 0010 OR, 0011 ADD, 0100 SUB, 0101 EQ (A==B), 0110 SLT (signed), 0111 SLT (signed, I-form), 1000 BGE (signed A≥B), 1001 SRL, 1010 SLL, 1011 SRA, 1100 LUI (pass B). Codes 1101–1111 → result 0, single-cycle.
- Compare ops return zero-extended 0/1. ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Accept (`in_valid && in_ready`) of non-shift op, or shift with shamt 0 → DONE, `ALUResult` = computed value (A for shamt 0).
- Accept of shift with shamt s>0 → SHIFT; A loaded into shift register, counter = s, op latched. Each SHIFT cycle: shift one bit (SRL fills 0, SRA fills sign, SLL fills 0), counter−1; on the cycle counter==1 go to DONE with final value.
- DONE: `out_valid`=1, `ALUResult` stable until `out_ready`. Handshake with no new accept → IDLE; with new accept → DONE or SHIFT per the rules above (back-to-back).
- `in_valid` is ignored during SHIFT. `SrcA`/`SrcB`/`Operation` are sampled only at accept.

## Timing
- Reset (async assert, any state, including mid-shift): state IDLE, `out_valid`=0, `ALUResult`=0, `Busy`=0, `in_ready`=1 the first cycle after release. Any in-flight op is discarded.
- Latency (accept edge → `out_valid` high): 1 cycle for non-shift or shamt 0; s+1 cycles for serial shift with shamt s (max DATA_WIDTH).
- Throughput: 1 op/cycle for single-cycle ops with `out_ready` held high.
- `out_valid` held with `out_ready`=0: `ALUResult` and `out_valid` unchanged, `in_ready`=0.
- `Busy` high exactly for the s cycles spent in SHIFT.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined: shifts are computed combinationally at accept. All ops have 1-cycle latency, the SHIFT state is unreachable, and `Busy` is tied to 0.
- Undefined: serial shifter as described (default).

## Test plan
- Reset mid-shift: SRL A=0x80000000, s=20, assert `reset` after 5 cycles → `out_valid`=0, `ALUResult`=0 immediately; `in_ready`=1 after release.
- ADD 0xFFFFFFFF+0x1, then SUB 0x5−0x7, back-to-back with `out_ready`=1 → 0x00000000, then 0xFFFFFFFE, on consecutive cycles.
- SRA A=0xF0000000, B=0x4 → `Busy` 4 cycles, `ALUResult`=0xFF000000 at latency 5. SLL A=0x1, B=0x1F → 0x80000000 at latency 32.
- SLT A=0xFFFFFFFF, B=0x1 → 0x1. BGE same operands → 0x0. EQ A=B=0x1234 → 0x1. LUI B=0xABCDE000 → 0xABCDE000.
- Backpressure: XOR 0xFF00FF00^0x0F0F0F0F with `out_ready`=0 for 3 cycles → 0xF00FF00F held stable, `in_ready`=0, and an `in_valid` offered meanwhile is not accepted.
- Shamt 0 SRL A=0x1234 → 0x1234 at latency 1, `Busy` never high. With `ALU_BARREL_SHIFT_EN`, SLL 0x1 by 31 → 0x80000000 at latency 1.
